// File: rtl/bless_router_param.sv
// rtl/bless_router_param.sv - parametrised 2-stage bufferless deflection mesh router
module bless_router_param #(
  parameter int DATA_W = 32,
  parameter int X_W    = 3,
  parameter int Y_W    = 3,
  parameter int AGE_W  = 6,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0,
  parameter int CNT_W  = 16,
  localparam int FLIT_W = 1 + AGE_W + X_W + Y_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] din_w,
  input  logic [FLIT_W-1:0] din_e,
  input  logic [FLIT_W-1:0] din_s,
  input  logic [FLIT_W-1:0] din_n,
  input  logic              inj_valid,
  input  logic [FLIT_W-1:0] inj_flit,
  output logic              inj_ready,
  output logic [FLIT_W-1:0] dout_w,
  output logic [FLIT_W-1:0] dout_e,
  output logic [FLIT_W-1:0] dout_s,
  output logic [FLIT_W-1:0] dout_n,
  output logic [FLIT_W-1:0] ej_flit,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  defl_cnt
);

  // Flit field positions: {valid, age, xdst, ydst, payload}
  localparam int Y_LSB = DATA_W;
  localparam int X_LSB = DATA_W + Y_W;
  localparam int A_LSB = DATA_W + Y_W + X_W;
  localparam int V_BIT = FLIT_W - 1;

  localparam logic [X_W-1:0]   CX      = X_W'(CUR_X);
  localparam logic [Y_W-1:0]   CY      = Y_W'(CUR_Y);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // Port indices double as the tie-break order among inputs
  localparam logic [1:0] P_W = 2'd0;
  localparam logic [1:0] P_E = 2'd1;
  localparam logic [1:0] P_S = 2'd2;
  localparam logic [1:0] P_N = 2'd3;

  logic [FLIT_W-1:0] in_q  [4];
  logic [FLIT_W-1:0] out_q [4];
  logic [FLIT_W-1:0] out_d [4];
  logic [FLIT_W-1:0] ej_q, ej_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        ndefl;
  logic              ready_c;

  // Returns {deflected, sel}; sel 0..3 is a link port, 4 is the ejector.
  function automatic logic [3:0] pick(input logic [FLIT_W-1:0] f,
                                      input logic [3:0] busy,
                                      input logic ej_b);
    logic [X_W-1:0] fx;
    logic [Y_W-1:0] fy;
    logic           hx, hy;
    logic [1:0]     px, py;
    logic [3:0]     r;
    fx = f[X_LSB +: X_W];
    fy = f[Y_LSB +: Y_W];
    hx = (fx != CX);
    hy = (fy != CY);
    px = (fx > CX) ? P_E : P_W;
    py = (fy > CY) ? P_N : P_S;
    if (!hx && !hy && !ej_b)      r = 4'b0100;
    else if (hx && !busy[px])     r = {2'b00, px};
    else if (hy && !busy[py])     r = {2'b00, py};
    else if (!busy[P_W])          r = {2'b10, P_W};
    else if (!busy[P_E])          r = {2'b10, P_E};
    else if (!busy[P_S])          r = {2'b10, P_S};
    else                          r = {2'b10, P_N};
    return r;
  endfunction

  // Link hop: bump age, saturating at all-ones
  function automatic logic [FLIT_W-1:0] hop(input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] g;
    g = f;
    if (f[A_LSB +: AGE_W] != AGE_MAX)
      g[A_LSB +: AGE_W] = f[A_LSB +: AGE_W] + 1'b1;
    return g;
  endfunction

  // Stage 2: oldest-first allocation of buffered flits, then the local flit last
  always_comb begin
    logic [3:0]        busy;
    logic              ej_b;
    logic [1:0]        rank [4];
    logic [2:0]        nvalid;
    logic [3:0]        sel;
    logic [FLIT_W-1:0] loc;
    busy   = '0;
    ej_b   = 1'b0;
    ndefl  = '0;
    nvalid = '0;
    ej_d   = '0;
    sel    = '0;
    for (int i = 0; i < 4; i++) out_d[i] = '0;
    for (int i = 0; i < 4; i++) begin
      rank[i] = '0;
      nvalid  = nvalid + {2'b00, in_q[i][V_BIT]};
      for (int j = 0; j < 4; j++) begin
        if (j != i && in_q[j][V_BIT] &&
            ((in_q[j][A_LSB +: AGE_W] > in_q[i][A_LSB +: AGE_W]) ||
             (in_q[j][A_LSB +: AGE_W] == in_q[i][A_LSB +: AGE_W] && j < i)))
          rank[i] = rank[i] + 2'd1;
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (in_q[i][V_BIT] && rank[i] == 2'(r)) begin
          sel = pick(in_q[i], busy, ej_b);
          if (sel[2]) begin
            ej_d = in_q[i];
            ej_b = 1'b1;
          end else begin
            out_d[sel[1:0]] = hop(in_q[i]);
            busy[sel[1:0]]  = 1'b1;
          end
          ndefl = ndefl + {2'b00, sel[3]};
        end
      end
    end
    // Space for the local flit exists when fewer than four buffered flits need a link
    ready_c = reset && ((nvalid - {2'b00, ej_b}) < 3'd4);
    loc = {1'b1, {AGE_W{1'b0}}, inj_flit[A_LSB-1:0]};
    if (inj_valid && ready_c) begin
      sel = pick(loc, busy, ej_b);
      if (sel[2]) ej_d = loc;
      else        out_d[sel[1:0]] = hop(loc);
      ndefl = ndefl + {2'b00, sel[3]};
    end
  end

  // Saturating deflection counter with clear taking priority
  always_comb begin
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt_q} + {{(CNT_W-2){1'b0}}, ndefl};
    if (stat_clr)        cnt_d = '0;
    else if (sum[CNT_W]) cnt_d = '1;
    else                 cnt_d = sum[CNT_W-1:0];
  end

  // Pipeline registers: input capture, output capture and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        in_q[i]  <= '0;
        out_q[i] <= '0;
      end
      ej_q  <= '0;
      cnt_q <= '0;
    end else begin
      in_q[0] <= din_w[V_BIT] ? din_w : '0;
      in_q[1] <= din_e[V_BIT] ? din_e : '0;
      in_q[2] <= din_s[V_BIT] ? din_s : '0;
      in_q[3] <= din_n[V_BIT] ? din_n : '0;
      for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
      ej_q  <= ej_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_w    = out_q[0];
  assign dout_e    = out_q[1];
  assign dout_s    = out_q[2];
  assign dout_n    = out_q[3];
  assign ej_flit   = ej_q;
  assign defl_cnt  = cnt_q;
  assign inj_ready = ready_c;

endmodule
